axis_pin_arbiter: RTL and testbench

Round-robin arbiter that shares one 64-bit AXI4-Stream master port between up to four 64-bit pin-capture stream sources. It grants one source for a whole burst of a runtime-configured beat count and closes each burst with TLAST. TDEST carries the source index and TID carries a rolling burst sequence number. It sits between the pin-source instances and the downstream DMA/FIFO, and turns their continuous, TLAST-free streams into packets.

---
 rtl/axis_pin_arbiter_if.sv | 29 ++
 rtl/axis_pin_arbiter.sv | 101 ++++++++++
 tb/tb_axis_pin_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pin_arbiter_if.sv
// axis_pin_arbiter_if: source-side and master-side AXI4-Stream signals of the pin arbiter
interface axis_pin_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 64
);
    logic [N_SRC-1:0]        s_axis_tvalid;
    logic [N_SRC*DATA_W-1:0] s_axis_tdata;
    logic [N_SRC-1:0]        s_axis_tready;
    logic                    m_axis_tvalid;
    logic [DATA_W-1:0]       m_axis_tdata;
    logic                    m_axis_tlast;
    logic [1:0]              m_axis_tdest;
    logic [3:0]              m_axis_tid;
    logic [DATA_W/8-1:0]     m_axis_tkeep;
    logic [DATA_W/8-1:0]     m_axis_tstrb;
    logic                    m_axis_tready;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
               m_axis_tdest, m_axis_tid, m_axis_tkeep, m_axis_tstrb
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
               m_axis_tdest, m_axis_tid, m_axis_tkeep, m_axis_tstrb
    );
endinterface

// File: rtl/axis_pin_arbiter.sv
// axis_pin_arbiter: round-robin packetiser sharing one AXI4-Stream master among pin-capture sources
module axis_pin_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 64
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               enable,
    input  logic [N_SRC-1:0]   src_en,
    input  logic [7:0]         cfg_burst_len,
    axis_pin_arbiter_if.master axis,
    output logic               busy,
    output logic [1:0]         grant_idx
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state;
    logic [1:0]        last_grant;
    logic [3:0]        seq_q;
    logic [7:0]        beat_cnt;
    logic [7:0]        len_q;
    logic [N_SRC-1:0]  req;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic              accept;
    logic              last_beat;
    logic [DATA_W-1:0] src_data [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_lane
        assign src_data[g] = axis.s_axis_tdata[g*DATA_W +: DATA_W];
    end

    assign req                = enable ? (axis.s_axis_tvalid & src_en) : '0;
    assign last_beat          = beat_cnt == len_q - 8'd1;
    assign busy               = state == GRANT;
    assign accept             = busy && axis.s_axis_tvalid[grant_idx] && axis.s_axis_tready[grant_idx];
    assign axis.m_axis_tkeep  = '1;
    assign axis.m_axis_tstrb  = '1;

    // first requester after last_grant, wrapping; walking the offsets downward leaves the nearest one
    always_comb begin
        pick = last_grant;
        idx  = last_grant;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = 2'((int'(last_grant) + k) % N_SRC);
            if (req[idx]) pick = idx;
        end
    end

    // only the granted source sees ready, and only while the output register can take a beat
    always_comb begin
        axis.s_axis_tready = '0;
        if (busy) axis.s_axis_tready[grant_idx] = !axis.m_axis_tvalid || axis.m_axis_tready;
    end

    // burst sequencing: grant from IDLE, count beats in GRANT, return after the TLAST accept
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            last_grant <= 2'(N_SRC - 1);
            seq_q      <= '0;
            beat_cnt   <= '0;
            len_q      <= 8'd1;
            grant_idx  <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state     <= GRANT;
                grant_idx <= pick;
                len_q     <= (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
                beat_cnt  <= '0;
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
                state      <= IDLE;
                last_grant <= grant_idx;
                seq_q      <= seq_q + 4'd1;
            end
        end
    end

    // output register: load on accept, empty when the downstream takes it without a refill
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tdata  <= '0;
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tdest  <= '0;
            axis.m_axis_tid    <= '0;
        end else if (accept) begin
            axis.m_axis_tvalid <= 1'b1;
            axis.m_axis_tdata  <= src_data[grant_idx];
            axis.m_axis_tlast  <= last_beat;
            axis.m_axis_tdest  <= grant_idx;
            axis.m_axis_tid    <= seq_q;
        end else if (axis.m_axis_tready) begin
            axis.m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_pin_arbiter.sv
// tb_axis_pin_arbiter: table vectors, directed corner sequences and random backpressure against a packet model
module tb_axis_pin_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [3:0] en;
        logic [3:0] valid;
        logic [7:0] cfg;
        int         len;
        int         dest;
        int         tid;
    } vec_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] src_en = '0;
    logic [7:0] cfg_burst_len = '0;
    logic       busy;
    logic [1:0] grant_idx;

    axis_pin_arbiter_if #(.N_SRC(N), .DATA_W(64)) bus ();

    axis_pin_arbiter #(.N_SRC(N), .DATA_W(64)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .src_en        (src_en),
        .cfg_burst_len (cfg_burst_len),
        .axis          (bus),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    always #5 aclk = ~aclk;

    logic [3:0][55:0] cnt = '0;
    for (genvar g = 0; g < N; g++) begin : g_src
        assign bus.s_axis_tdata[g*64 +: 64] = {8'(g), cnt[g]};
    end

    always @(posedge aclk)
        for (int i = 0; i < N; i++)
            if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i]) cnt[i] <= cnt[i] + 56'd1;

    int               n_chk = 0;
    int               n_fail = 0;
    logic [3:0]       m_req = '0;
    int               m_cfg = 1;
    logic [1:0]       m_last = 2'd3;
    logic [3:0]       m_seq = '0;
    logic [1:0]       m_src = '0;
    logic [3:0]       m_tid = '0;
    bit               m_in = 0;
    int               m_len = 1;
    int               m_beat = 0;
    int               m_started = 0;
    logic [3:0][55:0] exp_cnt = '0;
    int               log_dest[$];
    int               log_tid[$];
    int               log_len[$];
    bit               rnd_ready = 0;
    vec_t             vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_beat();
        logic [1:0] ix;
        bit found;
        if (!m_in) begin
            found = 0;
            for (int k = N; k >= 1; k--) begin
                ix = 2'((int'(m_last) + k) % N);
                if (m_req[ix]) begin
                    m_src = ix;
                    found = 1;
                end
            end
            check("grant_legal", 64'(found), 64'd1);
            if (!found) m_src = bus.m_axis_tdest;
            m_len = (m_cfg == 0) ? 1 : m_cfg;
            m_beat = 0;
            m_tid = m_seq;
            m_in = 1;
            m_started++;
        end
        check("tdest", 64'(bus.m_axis_tdest), 64'(m_src));
        check("tid", 64'(bus.m_axis_tid), 64'(m_tid));
        check("tdata", bus.m_axis_tdata, {8'(m_src), exp_cnt[m_src]});
        check("tlast", 64'(bus.m_axis_tlast), 64'(m_beat == m_len - 1));
        exp_cnt[m_src] = exp_cnt[m_src] + 56'd1;
        m_beat++;
        if (m_beat == m_len) begin
            log_dest.push_back(int'(m_src));
            log_tid.push_back(int'(m_tid));
            log_len.push_back(m_len);
            m_last = m_src;
            m_seq = m_seq + 4'd1;
            m_in = 0;
        end
    endtask

    initial begin
        logic        stall = 0;
        logic [63:0] s_data = '0;
        logic        s_last = 0;
        logic [1:0]  s_dest = '0;
        logic [3:0]  s_tid = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) stall = 0;
            else begin
                check("ready_onehot", 64'($countones(bus.s_axis_tready) <= 1), 64'd1);
                check("ready_masked", 64'(bus.s_axis_tready & ~src_en), 64'd0);
                if (stall) begin
                    check("stall_tdata", bus.m_axis_tdata, s_data);
                    check("stall_tlast", 64'(bus.m_axis_tlast), 64'(s_last));
                    check("stall_tdest", 64'(bus.m_axis_tdest), 64'(s_dest));
                    check("stall_tid", 64'(bus.m_axis_tid), 64'(s_tid));
                end
                stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                s_data = bus.m_axis_tdata;
                s_last = bus.m_axis_tlast;
                s_dest = bus.m_axis_tdest;
                s_tid = bus.m_axis_tid;
                if (bus.m_axis_tvalid && bus.m_axis_tready) model_beat();
            end
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rnd_ready) bus.m_axis_tready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_busy(input logic v);
        int t = 0;
        while (busy !== v && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        check("wait_busy", 64'(busy), 64'(v));
    endtask

    task automatic wait_started(input int n);
        int t = 0;
        while (m_started < n && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        check("wait_started", 64'(m_started >= n), 64'd1);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (!(m_in && m_beat >= n) && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        check("wait_beats", 64'(m_in && m_beat >= n), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        rnd_ready = 0;
        step();
        enable = 0;
        bus.m_axis_tready = 1;
        while ((busy || bus.m_axis_tvalid) && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        check("drain", 64'(busy || bus.m_axis_tvalid), 64'd0);
        step();
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2;
        aresetn = 0;
        #1;
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_tdata", bus.m_axis_tdata, 64'd0);
        check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        check("rst_tdest", 64'(bus.m_axis_tdest), 64'd0);
        check("rst_tid", 64'(bus.m_axis_tid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        repeat (2) step();
        m_in = 0;
        m_last = 2'd3;
        m_seq = '0;
        exp_cnt = cnt;
        aresetn = 1;
        step();
    endtask

    task automatic setup(input logic [3:0] en, input logic [3:0] valid, input logic [7:0] cfg);
        src_en = en;
        bus.s_axis_tvalid = valid;
        cfg_burst_len = cfg;
        m_cfg = int'(cfg);
        m_req = en & valid;
    endtask

    task automatic one_burst();
        enable = 1;
        wait_busy(1);
        step();
        enable = 0;
        drain();
    endtask

    initial begin
        int base;
        bus.s_axis_tvalid = '0;
        bus.m_axis_tready = 1;
        vecs[0] = '{4'hF, 4'hF, 8'd4,   4,   0, 0};
        vecs[1] = '{4'hF, 4'hF, 8'd0,   1,   1, 1};
        vecs[2] = '{4'hA, 4'hF, 8'd2,   2,   3, 2};
        vecs[3] = '{4'hA, 4'hF, 8'd1,   1,   1, 3};
        vecs[4] = '{4'hF, 4'h1, 8'd3,   3,   0, 4};
        vecs[5] = '{4'h4, 4'hF, 8'd5,   5,   2, 5};
        vecs[6] = '{4'hF, 4'hC, 8'd255, 255, 3, 6};
        vecs[7] = '{4'hF, 4'hF, 8'd2,   2,   0, 7};
        do_reset();

        for (int r = 0; r < 8; r++) begin
            base = log_dest.size();
            setup(vecs[r].en, vecs[r].valid, vecs[r].cfg);
            one_burst();
            check("row_bursts", 64'(log_dest.size() - base), 64'd1);
            if (log_dest.size() > base) begin
                check("row_dest", 64'(log_dest[base]), 64'(vecs[r].dest));
                check("row_tid", 64'(log_tid[base]), 64'(vecs[r].tid));
                check("row_len", 64'(log_len[base]), 64'(vecs[r].len));
            end
        end

        do_reset();
        base = log_dest.size();
        setup(4'hF, 4'hF, 8'd4);
        enable = 1;
        wait_started(m_started + 5);
        step();
        enable = 0;
        drain();
        check("dflt_bursts", 64'(log_dest.size() - base), 64'd5);
        for (int k = 0; k < 5 && base + k < log_dest.size(); k++) begin
            check("dflt_dest", 64'(log_dest[base + k]), 64'(k % 4));
            check("dflt_tid", 64'(log_tid[base + k]), 64'(k));
            check("dflt_len", 64'(log_len[base + k]), 64'd4);
        end

        base = log_dest.size();
        setup(4'hA, 4'hF, 8'($urandom_range(1, 6)));
        rnd_ready = 1;
        enable = 1;
        repeat (300) step();
        drain();
        check("mask_progress", 64'(log_dest.size() > base + 4), 64'd1);

        for (int p = 0; p < 4; p++) begin
            setup(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 9)));
            rnd_ready = 1;
            enable = 1;
            repeat (200) step();
            drain();
        end

        setup(4'hF, 4'hF, 8'd3);
        enable = 1;
        wait_busy(1);
        step();
        enable = 0;
        cfg_burst_len = 8'd6;
        drain();
        check("midlen_old", 64'(log_len[$]), 64'd3);
        m_cfg = 6;
        one_burst();
        check("midlen_new", 64'(log_len[$]), 64'd6);

        setup(4'hF, 4'hF, 8'd8);
        base = log_dest.size();
        enable = 1;
        wait_beats(2);
        step();
        enable = 0;
        drain();
        check("stop_bursts", 64'(log_dest.size() - base), 64'd1);
        check("stop_len", 64'(log_len[$]), 64'd8);
        repeat (10) begin
            @(negedge aclk);
            check("stop_busy", 64'(busy), 64'd0);
            check("stop_ready", 64'(bus.s_axis_tready), 64'd0);
        end

        step();
        setup(4'hF, 4'hF, 8'd8);
        enable = 1;
        wait_beats(3);
        step();
        enable = 0;
        do_reset();
        setup(4'hF, 4'hF, 8'd2);
        base = log_dest.size();
        one_burst();
        check("post_rst_bursts", 64'(log_dest.size() - base), 64'd1);
        check("post_rst_dest", 64'(log_dest[$]), 64'd0);
        check("post_rst_tid", 64'(log_tid[$]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
